// File: rtl/tt_sel_ctrl.sv
// Design-select controller: synchronises control pads, keeps a wrapping user-module address
// and holds off the spine enable while the muxes settle. Optional TT_SEL_LOAD_EN adds a direct address load.
module tt_sel_ctrl #(
    parameter int G_X           = 16,
    parameter int G_Y           = 16,
    parameter int N_ACTIVE      = G_X * G_Y,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 4,
    localparam int CW           = $clog2(G_X),
    localparam int BW           = $clog2(G_Y),
    localparam int AW           = BW + CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ctrl_sel_rst_n,
    input  logic          ctrl_sel_inc,
    input  logic          ctrl_ena,
`ifdef TT_SEL_LOAD_EN
    input  logic          load_stb,
    input  logic [AW-1:0] load_addr,
`endif
    output logic [BW-1:0] sel_branch,
    output logic [CW-1:0] sel_col,
    output logic          sel_ena,
    output logic          sel_busy
);

    localparam logic [7:0]    SETTLE_INIT = 8'(SETTLE_CYCLES);
    localparam logic [AW-1:0] ADDR_LAST   = AW'(N_ACTIVE - 1);

    logic [2:0] pad_raw;
    logic [2:0] pad_sync;
    logic       rst_s;
    logic       inc_s;
    logic       ena_s;

    assign pad_raw = {ctrl_ena, ctrl_sel_inc, ctrl_sel_rst_n};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], pad_raw[gi]};
                end
            end

            assign pad_sync[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    assign rst_s = pad_sync[0];
    assign inc_s = pad_sync[1];
    assign ena_s = pad_sync[2];

    logic          inc_q_reg;
    logic          inc_edge;
    logic [AW-1:0] addr_reg;
    logic [AW-1:0] addr_next;
    logic [7:0]    settle_reg;
    logic [7:0]    settle_next;

    assign inc_edge = inc_s & ~inc_q_reg;

`ifdef TT_SEL_LOAD_EN
    // Out-of-range loads behave as if the strobe were absent.
    logic load_ok;
    assign load_ok = load_stb && (load_addr <= ADDR_LAST);
`endif

    always_comb begin
        addr_next   = addr_reg;
        settle_next = settle_reg;
        if (!rst_s) begin
            addr_next   = '0;
            settle_next = SETTLE_INIT;
`ifdef TT_SEL_LOAD_EN
        end else if (load_ok) begin
            addr_next   = load_addr;
            settle_next = SETTLE_INIT;
`endif
        end else if (inc_edge) begin
            addr_next   = (addr_reg == ADDR_LAST) ? '0 : addr_reg + AW'(1);
            settle_next = SETTLE_INIT;
        end else if (settle_reg != 8'd0) begin
            settle_next = settle_reg - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_q_reg  <= 1'b0;
            addr_reg   <= '0;
            settle_reg <= SETTLE_INIT;
        end else begin
            inc_q_reg  <= inc_s;
            addr_reg   <= addr_next;
            settle_reg <= settle_next;
        end
    end

    // Outputs come from registers only so no pad glitch reaches the spine.
    assign sel_branch = addr_reg[AW-1:CW];
    assign sel_col    = addr_reg[CW-1:0];
    assign sel_busy   = (settle_reg != 8'd0);
    assign sel_ena    = rst_s & ena_s & ~sel_busy;

endmodule

// File: tb/tb_tt_sel_ctrl.sv
// Bench for tt_sel_ctrl: table of increment runs, a scoreboard of address updates,
// and hand-written reset / settle / load corner sequences.
module tb_tt_sel_ctrl;

    localparam int N_ACT = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ctrl_sel_rst_n = 1'b1;
    logic       ctrl_sel_inc = 1'b0;
    logic       ctrl_ena = 1'b1;
    logic [3:0] sel_branch;
    logic [3:0] sel_col;
    logic       sel_ena;
    logic       sel_busy;
`ifdef TT_SEL_LOAD_EN
    logic       load_stb = 1'b0;
    logic [7:0] load_addr = 8'd0;
`endif

    tt_sel_ctrl #(
        .G_X(16), .G_Y(16), .N_ACTIVE(N_ACT), .SYNC_STAGES(2), .SETTLE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ctrl_sel_rst_n(ctrl_sel_rst_n),
        .ctrl_sel_inc(ctrl_sel_inc),
        .ctrl_ena(ctrl_ena),
`ifdef TT_SEL_LOAD_EN
        .load_stb(load_stb),
        .load_addr(load_addr),
`endif
        .sel_branch(sel_branch),
        .sel_col(sel_col),
        .sel_ena(sel_ena),
        .sel_busy(sel_busy)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         exp_q[$];
    int         model_addr = 0;
    bit         mon_en = 1'b0;
    logic [7:0] prev_addr = 8'd0;
    logic [7:0] cur_addr;

    assign cur_addr = {sel_branch, sel_col};

    typedef struct {
        int npulse;
        int width;
        int exp_br;
        int exp_col;
    } vec_t;

    vec_t tbl[6];
    int   inc_pat[12];
    int   busy_pat[12];
    int   offs_pat[12];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every visible address change must match the next queued expectation.
    always @(negedge clk) begin
        if (mon_en && cur_addr != prev_addr) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_unexpected: got addr %0d expected no change", cur_addr);
            end else begin
                int e;
                e = exp_q.pop_front();
                $display("addr update: %0d (expected %0d) at %0t", cur_addr, e, $time);
                check("mon_addr", int'(cur_addr), e);
            end
        end
        prev_addr = cur_addr;
    end

    task automatic pulse(input int w);
        model_addr = (model_addr == N_ACT - 1) ? 0 : model_addr + 1;
        exp_q.push_back(model_addr);
        ctrl_sel_inc = 1'b1;
        repeat (w) tick();
        ctrl_sel_inc = 1'b0;
        repeat (w) tick();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (3) tick();
        while (sel_busy && n < 60) begin
            tick();
            n++;
        end
        check(name, int'(sel_busy), 0);
    endtask

    // After rst_n release with pads idle-high: busy until 4 cycles after rst_s rises.
    task automatic check_release(input string name);
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            @(negedge clk);
            check({name, "_busy"}, int'(sel_busy), (e < 6) ? 1 : 0);
            check({name, "_ena"}, int'(sel_ena), (e < 6) ? 0 : 1);
        end
    endtask

    initial begin
        tbl[0] = '{npulse: 3,  width: 4, exp_br: 0, exp_col: 3};
        tbl[1] = '{npulse: 14, width: 3, exp_br: 1, exp_col: 1};
        tbl[2] = '{npulse: 1,  width: 5, exp_br: 1, exp_col: 2};
        tbl[3] = '{npulse: 21, width: 3, exp_br: 2, exp_col: 7};
        tbl[4] = '{npulse: 1,  width: 3, exp_br: 0, exp_col: 0};
        tbl[5] = '{npulse: 2,  width: 4, exp_br: 0, exp_col: 2};
        inc_pat  = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0};
        busy_pat = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        offs_pat = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_branch", int'(sel_branch), 0);
        check("rst_col", int'(sel_col), 0);
        check("rst_ena", int'(sel_ena), 0);
        check("rst_busy", int'(sel_busy), 1);
        $display("reset applied, releasing rst_n");
        rst_n = 1'b1;
        check_release("rel");
        mon_en = 1'b1;

        // Table-driven increment runs, including branch carry and wrap at N_ACTIVE-1
        for (int i = 0; i < 6; i++) begin
            for (int p = 0; p < tbl[i].npulse; p++) pulse(tbl[i].width);
            wait_idle("tbl_idle");
            check("tbl_branch", int'(sel_branch), tbl[i].exp_br);
            check("tbl_col", int'(sel_col), tbl[i].exp_col);
            check("tbl_ena", int'(sel_ena), 1);
            $display("row %0d: %0d pulses -> branch %0d col %0d", i, tbl[i].npulse, sel_branch, sel_col);
        end

        // Two-edge latency and second increment during settle reloading the guard
        begin
            int base;
            base = model_addr;
            tick();
            model_addr = base + 2;
            exp_q.push_back(base + 1);
            exp_q.push_back(base + 2);
            ctrl_sel_inc = inc_pat[1][0];
            for (int e = 1; e <= 11; e++) begin
                @(posedge clk);
                #1;
                ctrl_sel_inc = (e < 11) ? inc_pat[e+1][0] : 1'b0;
                @(negedge clk);
                check("seq_busy", int'(sel_busy), busy_pat[e]);
                check("seq_addr", int'(cur_addr), base + offs_pat[e]);
            end
            $display("settle sequence: addr %0d -> %0d", base, cur_addr);
        end

        // Held strobe gives a single increment
        model_addr = model_addr + 1;
        exp_q.push_back(model_addr);
        ctrl_sel_inc = 1'b1;
        repeat (50) tick();
        ctrl_sel_inc = 1'b0;
        wait_idle("hold_idle");
        check("hold_addr", int'(cur_addr), model_addr);
        $display("held strobe: addr %0d", cur_addr);

        // Enable pad alone touches neither address nor guard
        ctrl_ena = 1'b0;
        repeat (3) tick();
        check("ena_low_ena", int'(sel_ena), 0);
        check("ena_low_busy", int'(sel_busy), 0);
        ctrl_ena = 1'b1;
        repeat (3) tick();
        check("ena_high_ena", int'(sel_ena), 1);
        check("ena_addr", int'(cur_addr), model_addr);
        $display("enable toggle: addr %0d ena %0d", cur_addr, sel_ena);

        // Select-reset arriving with the increment edge: increment discarded
        model_addr = 0;
        exp_q.push_back(0);
        ctrl_sel_inc = 1'b1;
        ctrl_sel_rst_n = 1'b0;
        repeat (3) tick();
        check("col_addr", int'(cur_addr), 0);
        check("col_ena", int'(sel_ena), 0);
        check("col_busy", int'(sel_busy), 1);
        repeat (3) tick();
        ctrl_sel_rst_n = 1'b1;
        check_release("col_rel");
        check("col_rel_addr", int'(cur_addr), 0);
        ctrl_sel_inc = 1'b0;
        repeat (3) tick();
        $display("select-reset collision: addr %0d", cur_addr);

        // rst_n asserted mid-settle takes effect without a clock edge
        model_addr = 1;
        exp_q.push_back(1);
        ctrl_sel_inc = 1'b1;
        repeat (4) tick();
        check("mid_busy_pre", int'(sel_busy), 1);
        ctrl_sel_inc = 1'b0;
        model_addr = 0;
        exp_q.push_back(0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_branch", int'(sel_branch), 0);
        check("mid_col", int'(sel_col), 0);
        check("mid_ena", int'(sel_ena), 0);
        check("mid_busy", int'(sel_busy), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_release("mid_rel");
        $display("rst_n mid-settle: addr %0d", cur_addr);

`ifdef TT_SEL_LOAD_EN
        // Direct load, out-of-range load, and load beating a coincident increment
        tick();
        load_addr = 8'h25;
        load_stb = 1'b1;
        model_addr = 37;
        exp_q.push_back(37);
        tick();
        load_stb = 1'b0;
        check("ld_branch", int'(sel_branch), 2);
        check("ld_col", int'(sel_col), 5);
        repeat (3) tick();
        check("ld_busy3", int'(sel_busy), 1);
        tick();
        check("ld_busy4", int'(sel_busy), 0);
        load_addr = 8'd40;
        load_stb = 1'b1;
        tick();
        load_stb = 1'b0;
        repeat (2) tick();
        check("ld_oob_addr", int'(cur_addr), 37);
        ctrl_sel_inc = 1'b1;
        tick();
        tick();
        load_addr = 8'd7;
        load_stb = 1'b1;
        model_addr = 7;
        exp_q.push_back(7);
        tick();
        load_stb = 1'b0;
        check("ld_inc_addr", int'(cur_addr), 7);
        ctrl_sel_inc = 1'b0;
        wait_idle("ld_idle");
        check("ld_inc_final", int'(cur_addr), 7);
        $display("load tests: addr %0d", cur_addr);
`endif

        repeat (4) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
